// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops `len` words from a FIFO (1-cycle read latency) and streams them
// out with valid/ready through a 2-entry buffer. Define READER_LAST_EN to add the o_last output.
module fifo_burst_reader #(
  parameter int unsigned bw    = 4,
  parameter int unsigned width = 1,
  parameter int unsigned LEN_W = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  input  logic                  i_empty,
  output logic                  o_rd,
  input  logic [width*bw-1:0]   i_data,
  output logic                  o_valid,
  output logic [width*bw-1:0]   o_data,
  input  logic                  i_ready
`ifdef READER_LAST_EN
  ,
  output logic                  o_last
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_issued;
  logic [LEN_W-1:0]    r_delivered;
  logic [LEN_W-1:0]    w_deliv_nxt;
  logic                r_inflight;
  logic [1:0]          r_occ;
  logic [width*bw-1:0] r_buf0;
  logic [width*bw-1:0] r_buf1;
  logic                w_valid;
  logic                w_pop;
  logic                w_rd;
  logic [2:0]          w_need;
  logic [2:0]          w_cap;

  // Head is buf0 when anything is stored, else the word arriving from the FIFO this cycle.
  assign w_valid = (r_occ != 2'd0) | r_inflight;
  assign w_pop   = w_valid & i_ready;
  assign w_need  = 3'(r_occ) + 3'(r_inflight) + 3'd1;
  assign w_cap   = 3'd2 + 3'(w_pop);
  assign w_rd    = (r_state == StRun) & ~i_empty & (r_issued < r_len) & (w_need <= w_cap);
  assign w_deliv_nxt = r_delivered + LEN_W'(w_pop);

  assign o_rd    = w_rd;
  assign o_valid = w_valid;
  assign o_data  = (r_occ != 2'd0) ? r_buf0 : (r_inflight ? i_data : '0);
  assign busy    = (r_state == StRun) | (r_state == StFlush);
  assign done    = (r_state == StDone);

`ifdef READER_LAST_EN
  logic [LEN_W-1:0] w_deliv_inc;
  assign w_deliv_inc = r_delivered + LEN_W'(1);
  assign o_last      = w_valid & (w_deliv_inc == r_len);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (start) w_state_nxt = (len == '0) ? StDone : StRun;
      end
      StRun, StFlush: begin
        // Everything delivered implies nothing buffered or in flight.
        if (w_deliv_nxt == r_len)                        w_state_nxt = StDone;
        else if ((r_state == StRun) && (r_issued == r_len)) w_state_nxt = StFlush;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == StIdle) && start) begin
        r_len       <= len;
        r_issued    <= '0;
        r_delivered <= '0;
      end else if (busy) begin
        r_issued    <= r_issued + LEN_W'(w_rd);
        r_delivered <= w_deliv_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= w_rd;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= i_data;
          else               r_buf1 <= i_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Empty buffer: the arriving word bypasses straight out and is not stored.
          if (r_occ == 2'd1) begin
            r_buf0 <= i_data;
          end else if (r_occ == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model, stream monitor and queue-based
// reference of the expected word order; directed scenarios plus randomized bursts.
module tb_fifo_burst_reader;
  localparam int BW    = 4;
  localparam int WIDTH = 1;
  localparam int LEN_W = 7;
  localparam int DW    = BW * WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             i_empty;
  logic             o_rd;
  logic [DW-1:0]    i_data = '0;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             i_ready;
`ifdef READER_LAST_EN
  logic             o_last;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fifo_mem [0:4095];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            rd_cnt = 0;
  int            acc_cnt = 0;
  logic          force_empty;
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] got_q[$];
  int            cur_len = 0;
  int            last_acc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo_burst_reader #(.bw(BW), .width(WIDTH), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .i_empty (i_empty),
    .o_rd    (o_rd),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
`ifdef READER_LAST_EN
    ,
    .o_last  (o_last)
`endif
  );

  always #5 clk = ~clk;

  assign i_empty = (rd_ptr == wr_ptr) || force_empty;

  // FIFO model: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (reset) begin
      rd_cnt <= 0;
    end else if (o_rd && (rd_ptr != wr_ptr)) begin
      i_data <= fifo_mem[rd_ptr[11:0]];
      rd_ptr <= rd_ptr + 1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Stream monitor: collects accepted words and checks handshake rules every cycle.
  always @(negedge clk) begin
    if (reset) begin
      acc_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (o_rd) begin
        n_tests++;
        if (i_empty) begin
          n_fail++;
          $display("FAIL pop_empty: o_rd=%b while i_empty=%b, required no pop", o_rd, i_empty);
        end
      end
      n_tests++;
      if (rd_cnt - acc_cnt > 2) begin
        n_fail++;
        $display("FAIL occupancy: %0d words held/in flight, required <= 2", rd_cnt - acc_cnt);
      end
      if (prev_stall) begin
        n_tests++;
        if (!o_valid || o_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                   o_valid, o_data, prev_data);
        end
      end
`ifdef READER_LAST_EN
      n_tests++;
      if (o_last !== (o_valid && (got_q.size() == cur_len - 1))) begin
        n_fail++;
        $display("FAIL last_flag: o_last=%b, required %b", o_last,
                 (o_valid && (got_q.size() == cur_len - 1)));
      end
`endif
      if (o_valid && i_ready) begin
`ifdef READER_LAST_EN
        if (o_last) last_acc++;
`endif
        got_q.push_back(o_data);
        acc_cnt++;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem[wr_ptr[11:0]] = w;
    wr_ptr++;
    ref_q.push_back(w);
  endtask

  // Runs one burst of L words; expected words come off the front of ref_q.
  task automatic run_burst(input int L, input int mode, input int empty_at);
    int c, ndone, post;
    logic busy_seen;
    logic [DW-1:0] e;
    got_q.delete();
    cur_len  = L;
    last_acc = 0;
    c = 0; ndone = 0; post = 0;
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(L);
    i_ready = (mode == 2) ? ($urandom % 3 != 0) : 1'b1;
    force_empty = (empty_at == 0);
    while (c < 400 && !(ndone > 0 && post >= 3)) begin
      @(negedge clk);
      busy_seen = busy;
      if (done) ndone++;
      if (ndone > 0) post++;
      @(posedge clk); #1;
      c++;
      // start pulses while busy must be ignored
      start = busy_seen && ($urandom % 4 == 0);
      len   = LEN_W'($urandom);
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (c % 2 == 0);
        2:       i_ready = ($urandom % 3 != 0);
        default: i_ready = (got_q.size() != 2) || (c >= 12);
      endcase
      force_empty = (c >= empty_at) && (c < empty_at + 5);
    end
    start = 1'b0;
    force_empty = 1'b0;
    n_tests++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL done_count len=%0d: %0d done pulses, required 1", L, ndone);
    end
    n_tests++;
    if (got_q.size() != L) begin
      n_fail++;
      $display("FAIL word_count len=%0d: %0d words, required %0d", L, got_q.size(), L);
    end
    for (int i = 0; i < L; i++) begin
      e = ref_q.pop_front();
      if (i < got_q.size()) begin
        n_tests++;
        if (got_q[i] !== e) begin
          n_fail++;
          $display("FAIL word_order len=%0d idx=%0d: got %h, required %h", L, i, got_q[i], e);
        end
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after len=%0d: busy=%b, required 0", L, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, o_rd, o_valid, o_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs %b, required all zero", {busy, done, o_rd, o_valid, o_data});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, o_rd, o_valid, o_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: outputs %b, required all zero",
               {busy, done, o_rd, o_valid, o_data});
    end
  endtask

  task automatic test_throughput();
    logic [7:0] e_rd, e_vld, e_done, e_busy;
    logic [DW-1:0] e;
    e_rd   = 8'b0001_1110;
    e_vld  = 8'b0011_1100;
    e_done = 8'b0100_0000;
    e_busy = 8'b0011_1110;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    got_q.delete();
    cur_len = 4;
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(4); i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++;
      if ({o_rd, o_valid, done, busy} !== {e_rd[c], e_vld[c], e_done[c], e_busy[c]}) begin
        n_fail++;
        $display("FAIL tput_ctrl cyc=%0d: rd/valid/done/busy=%b, required %b", c,
                 {o_rd, o_valid, done, busy}, {e_rd[c], e_vld[c], e_done[c], e_busy[c]});
      end
      if (e_vld[c]) begin
        n_tests++;
        if (o_data !== DW'(c - 1)) begin
          n_fail++;
          $display("FAIL tput_data cyc=%0d: got %h, required %h", c, o_data, DW'(c - 1));
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      len   = LEN_W'($urandom);
    end
    n_tests++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL tput_count: %0d words, required 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      e = ref_q.pop_front();
      if (i < got_q.size()) begin
        n_tests++;
        if (got_q[i] !== e) begin
          n_fail++;
          $display("FAIL tput_order idx=%0d: got %h, required %h", i, got_q[i], e);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    push_word(DW'($urandom));
    got_q.delete();
    cur_len = 0;
    @(posedge clk); #1;
    start = 1'b1; len = '0; i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({o_rd, o_valid, busy, done} !== {3'b000, (c == 1)}) begin
        n_fail++;
        $display("FAIL zero_len cyc=%0d: rd/valid/busy/done=%b, required %b", c,
                 {o_rd, o_valid, busy, done}, {3'b000, (c == 1)});
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_len_words: %0d words, required 0", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    run_burst(8, 1, 1000);
  endtask

  task automatic test_empty_stall();
    for (int i = 0; i < 6; i++) push_word(DW'($urandom));
    run_burst(6, 0, 3);
  endtask

`ifdef READER_LAST_EN
  task automatic test_last();
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    run_burst(3, 3, 1000);
    n_tests++;
    if (last_acc != 1) begin
      n_fail++;
      $display("FAIL last_count: %0d accepted words flagged last, required 1", last_acc);
    end
  endtask
`endif

  task automatic test_random();
    int L;
    for (int k = 0; k < 6; k++) begin
      L = $urandom_range(1, 20);
      for (int i = 0; i < L + int'($urandom_range(0, 2)); i++) push_word(DW'($urandom));
      run_burst(L, 2, (k % 2 == 0) ? int'($urandom_range(1, 15)) : 1000);
    end
    // Maximum burst length
    for (int i = 0; i < 127; i++) push_word(DW'($urandom));
    run_burst(127, 0, 1000);
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    got_q.delete();
    cur_len = 2;
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(2); i_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (!(busy && o_valid && (rd_cnt - acc_cnt == 2))) begin
      n_fail++;
      $display("FAIL flush_setup: busy=%b valid=%b held=%0d, required 1/1/2",
               busy, o_valid, rd_cnt - acc_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, o_rd, o_valid, o_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: outputs %b, required all zero",
               {busy, done, o_rd, o_valid, o_data});
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    wr_ptr = rd_ptr;
    ref_q.delete();
    push_word(DW'($urandom));
    push_word(DW'($urandom));
    run_burst(2, 0, 1000);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; i_ready = 1'b0; force_empty = 1'b0;
    test_reset();
    test_throughput();
    test_zero_len();
    test_backpressure();
    test_empty_stall();
`ifdef READER_LAST_EN
    test_last();
`endif
    test_random();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
